axi4_stream_video_source: RTL

- Parameterised AXI4-Stream video master (test-pattern source). It is the transmitting end of the video stream interface used by the stream-terminator sinks.
- Emits complete frames with TUSER marking start-of-frame and TLAST marking end-of-line, and fully honours TREADY backpressure.
- Feeds VDMA/processing IP and sinks during board bring-up and simulation.

---
 rtl/axi4_stream_video_pkg.sv | 24 ++
 rtl/video_pattern_gen.sv | 48 ++++
 rtl/axi4_stream_video_source.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_video_pkg.sv
// Shared types and constants for the AXI4-Stream video test-pattern source:
// FSM encoding, pattern codes and stream width helpers.
package axi4_stream_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_DIAG  = 2'd3;

  localparam int NUM_BARS   = 8;
  localparam int BAR_W_BITS = 13;

  function automatic int axis_bytes(input int spc, input int mdw, input int nvc);
    return (spc * mdw * nvc + 7) / 8;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational pixel generator: turns pattern code, per-sample pixel index,
// line, frame counter and bar index into one beat of stream data.
module video_pattern_gen
  import axi4_stream_video_pkg::*;
#(
  parameter int NUM_VIDEO_COMPONENTS = 3,
  parameter int SAMPLES_PER_CLOCK    = 1,
  parameter int MAXIMUM_DATA_WIDTH   = 8,
  parameter int DATA_WIDTH           = 24
) (
  input  logic [1:0]                                         pattern,
  input  logic [SAMPLES_PER_CLOCK-1:0][MAXIMUM_DATA_WIDTH-1:0] px,
  input  logic [MAXIMUM_DATA_WIDTH-1:0]                      line,
  input  logic [MAXIMUM_DATA_WIDTH-1:0]                      frame_cnt,
  input  logic [SAMPLES_PER_CLOCK-1:0][2:0]                  bar_idx,
  output logic [DATA_WIDTH-1:0]                              tdata
);

  localparam int MDW = MAXIMUM_DATA_WIDTH;
  localparam int NVC = NUM_VIDEO_COMPONENTS;
  localparam int SPC = SAMPLES_PER_CLOCK;

  logic [SPC-1:0][NVC-1:0][MDW-1:0] pix;
  logic [MDW-1:0]                   comp;
  logic [2:0]                       bar_bits;

  always_comb begin
    pix      = '0;
    comp     = '0;
    bar_bits = '0;
    for (int s = 0; s < SPC; s++) begin
      // Bar 0 is white, bar 7 is black: each component keys off one bit of 7-b.
      bar_bits = 3'd7 - bar_idx[s];
      for (int c = 0; c < NVC; c++) begin
        case (pattern)
          PAT_SOLID: comp = MDW'(1) << (MDW - 1);
          PAT_RAMP:  comp = px[s];
          PAT_BARS:  comp = (|(bar_bits & (3'b001 << (c % 3)))) ? '1 : '0;
          default:   comp = px[s] + line + frame_cnt;
        endcase
        pix[s][c] = comp;
      end
    end
  end

  assign tdata = DATA_WIDTH'(pix);

endmodule

// File: rtl/axi4_stream_video_source.sv
// AXI4-Stream video test-pattern master with TUSER=SOF and TLAST=EOL.
// Optional stall statistics: define AXI4_STREAM_VIDEO_SOURCE_STALL_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for enable
// LATCH  | capture frame geometry and pattern, register first beat
// ACTIVE | streaming beats, advancing on TVALID & TREADY
// DONE   | one-cycle frame_done pulse, frame counter advances
module axi4_stream_video_source
  import axi4_stream_video_pkg::*;
#(
  parameter int NUM_VIDEO_COMPONENTS = 3,
  parameter int SAMPLES_PER_CLOCK    = 1,
  parameter int MAXIMUM_DATA_WIDTH   = 8,
  parameter int M_AXIS_BYTES = axis_bytes(SAMPLES_PER_CLOCK, MAXIMUM_DATA_WIDTH, NUM_VIDEO_COMPONENTS),
  parameter int M_AXIS_WIDTH = M_AXIS_BYTES * 8
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    enable,
  input  logic [15:0]             frame_width,
  input  logic [15:0]             frame_height,
  input  logic [1:0]              pattern_sel,
  output logic [M_AXIS_WIDTH-1:0] m_axis_video_TDATA,
  output logic                    m_axis_video_TVALID,
  input  logic                    m_axis_video_TREADY,
  output logic [M_AXIS_BYTES-1:0] m_axis_video_TKEEP,
  output logic [M_AXIS_BYTES-1:0] m_axis_video_TSTRB,
  output logic                    m_axis_video_TUSER,
  output logic                    m_axis_video_TLAST,
  output logic                    m_axis_video_TID,
  output logic                    m_axis_video_TDEST,
  output logic                    frame_done,
  output logic [31:0]             stall_count
);

  localparam int MDW = MAXIMUM_DATA_WIDTH;
  localparam int SPC = SAMPLES_PER_CLOCK;

  state_t                  state;
  logic [15:0]             bpl_r, height_r, x, y;
  logic [1:0]              pat_r;
  logic [BAR_W_BITS-1:0]   bar_w_r, bar_sc;
  logic [2:0]              bar_b;
  logic [MDW-1:0]          frame_cnt;

  logic                    latching, line_end, next_last;
  logic [15:0]             bpl_in, nx, ny;
  logic [BAR_W_BITS-1:0]   bar_w_in, cur_bar_w, walk_sc;
  logic [2:0]              walk_b;
  logic [1:0]              cur_pat;
  logic [SPC-1:0][MDW-1:0] px;
  logic [SPC-1:0][2:0]     bar_idx;
  logic [M_AXIS_WIDTH-1:0] beat_data;

  assign latching  = (state == ST_LATCH);
  assign bpl_in    = 16'(frame_width / 16'(SPC));
  assign bar_w_in  = (frame_width[15:3] == '0) ? BAR_W_BITS'(1) : frame_width[15:3];
  assign cur_bar_w = latching ? bar_w_in : bar_w_r;
  assign cur_pat   = latching ? pattern_sel : pat_r;
  assign line_end  = (x == bpl_r - 16'd1);
  assign nx        = (latching || line_end) ? 16'd0 : x + 16'd1;
  assign ny        = latching ? 16'd0 : (line_end ? y + 16'd1 : y);
  assign next_last = (nx == (latching ? bpl_in : bpl_r) - 16'd1);

  // Walk the bar sub-counter across the samples of the beat about to be registered.
  always_comb begin
    walk_b  = (nx == 16'd0) ? 3'd0 : bar_b;
    walk_sc = (nx == 16'd0) ? '0 : bar_sc;
    px      = '0;
    bar_idx = '0;
    for (int s = 0; s < SPC; s++) begin
      px[s]      = MDW'(32'(nx) * SPC + s);
      bar_idx[s] = walk_b;
      if (walk_sc == cur_bar_w - BAR_W_BITS'(1)) begin
        walk_sc = '0;
        if (walk_b != 3'd7) walk_b = walk_b + 3'd1;
      end else begin
        walk_sc = walk_sc + BAR_W_BITS'(1);
      end
    end
  end

  video_pattern_gen #(
    .NUM_VIDEO_COMPONENTS(NUM_VIDEO_COMPONENTS),
    .SAMPLES_PER_CLOCK   (SAMPLES_PER_CLOCK),
    .MAXIMUM_DATA_WIDTH  (MAXIMUM_DATA_WIDTH),
    .DATA_WIDTH          (M_AXIS_WIDTH)
  ) u_pattern_gen (
    .pattern  (cur_pat),
    .px       (px),
    .line     (MDW'(ny)),
    .frame_cnt(frame_cnt),
    .bar_idx  (bar_idx),
    .tdata    (beat_data)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state               <= ST_IDLE;
      bpl_r               <= '0;
      height_r            <= '0;
      pat_r               <= '0;
      bar_w_r             <= '0;
      bar_b               <= '0;
      bar_sc              <= '0;
      x                   <= '0;
      y                   <= '0;
      frame_cnt           <= '0;
      m_axis_video_TDATA  <= '0;
      m_axis_video_TVALID <= 1'b0;
      m_axis_video_TUSER  <= 1'b0;
      m_axis_video_TLAST  <= 1'b0;
      frame_done          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (enable) state <= ST_LATCH;
        ST_LATCH: begin
          bpl_r    <= bpl_in;
          height_r <= frame_height;
          pat_r    <= pattern_sel;
          bar_w_r  <= bar_w_in;
          if (bpl_in == 16'd0 || frame_height == 16'd0) begin
            state <= ST_IDLE;
          end else begin
            state               <= ST_ACTIVE;
            x                   <= 16'd0;
            y                   <= 16'd0;
            bar_b               <= walk_b;
            bar_sc              <= walk_sc;
            m_axis_video_TDATA  <= beat_data;
            m_axis_video_TVALID <= 1'b1;
            m_axis_video_TUSER  <= 1'b1;
            m_axis_video_TLAST  <= next_last;
          end
        end
        ST_ACTIVE: if (m_axis_video_TVALID && m_axis_video_TREADY) begin
          if (line_end && y == height_r - 16'd1) begin
            state               <= ST_DONE;
            m_axis_video_TVALID <= 1'b0;
            m_axis_video_TUSER  <= 1'b0;
            m_axis_video_TLAST  <= 1'b0;
            frame_done          <= 1'b1;
          end else begin
            x                  <= nx;
            y                  <= ny;
            bar_b              <= walk_b;
            bar_sc             <= walk_sc;
            m_axis_video_TDATA <= beat_data;
            m_axis_video_TUSER <= 1'b0;
            m_axis_video_TLAST <= next_last;
          end
        end
        ST_DONE: begin
          frame_cnt <= frame_cnt + MDW'(1);
          state     <= enable ? ST_LATCH : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXI4_STREAM_VIDEO_SOURCE_STALL_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      stall_q <= '0;
    end else if (state == ST_LATCH) begin
      stall_q <= '0;
    end else if (m_axis_video_TVALID && !m_axis_video_TREADY && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

  assign m_axis_video_TKEEP = '1;
  assign m_axis_video_TSTRB = '1;
  assign m_axis_video_TID   = 1'b0;
  assign m_axis_video_TDEST = 1'b0;

endmodule
